ofdm_qam4_demod: RTL

- Receive-side counterpart of the 4-subcarrier QAM4 OFDM modulator.
- Accepts one 32-sample OFDM symbol serially, one complex sample per cycle, in natural order m=0..31. This is the same order the modulator's out0..out31 present.
- Correlates the symbol against the 4 data subcarriers n ∈ {0,1,3,7} with parallel complex MACs. Slices each result to a QAM4 point and emits the recovered byte with a one-cycle valid strobe.
- Sits between the sample source (ADC / loopback of the modulator) and the byte sink.

---
 rtl/ofdm_pkg.sv | 18 +
 rtl/twiddle_rom32.sv | 23 ++
 rtl/ofdm_qam4_demod.sv | 95 +++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared OFDM/QAM4 constants, FSM states and the QAM4 slicer
package ofdm_pkg;
  localparam int N_FFT = 32;
  localparam int LOG2_N = 5;
  localparam int N_BINS = 4;
  localparam int BINS [N_BINS] = '{0, 1, 3, 7};
  localparam int Q_FRAC = 8;
  // QAM4 points sit at +/-QAM_ONE per axis
  localparam int QAM_ONE = 1 << Q_FRAC;
  localparam logic [1:0] SYM_PP = 2'd0;
  localparam logic [1:0] SYM_NP = 2'd1;
  localparam logic [1:0] SYM_NN = 2'd2;
  localparam logic [1:0] SYM_PN = 2'd3;
  typedef enum logic [1:0] {ACCUM, DECIDE, OUT} state_t;
  function automatic logic [1:0] qam4_slice(input logic re_neg, input logic im_neg);
    return im_neg ? (re_neg ? SYM_NN : SYM_PN) : (re_neg ? SYM_NP : SYM_PP);
  endfunction
endpackage

// File: rtl/twiddle_rom32.sv
// twiddle_rom32: four-port combinational cos/sin table for 32-point twiddles
module twiddle_rom32 import ofdm_pkg::*; #(
  parameter int WORD_SIZE = 16
) (
  input  logic        [LOG2_N-1:0]    idx     [N_BINS],
  output logic signed [WORD_SIZE-1:0] cos_val [N_BINS],
  output logic signed [WORD_SIZE-1:0] sin_val [N_BINS]
);
  // first quadrant of cos in Q8; other quadrants by symmetry
  localparam int QT [9] = '{QAM_ONE, 251, 237, 213, 181, 142, 98, 50, 0};
  function automatic logic signed [WORD_SIZE-1:0] cos_lut(input logic [LOG2_N-1:0] k);
    logic signed [WORD_SIZE-1:0] a, b;
    a = WORD_SIZE'(QT[{1'b0, k[2:0]}]);
    b = WORD_SIZE'(QT[4'd8 - {1'b0, k[2:0]}]);
    return k[3] ? (k[4] ? b : -b) : (k[4] ? -a : a);
  endfunction
  always_comb begin
    for (int p = 0; p < N_BINS; p++) begin
      cos_val[p] = cos_lut(idx[p]);
      sin_val[p] = cos_lut(idx[p] - LOG2_N'(8));
    end
  end
endmodule

// File: rtl/ofdm_qam4_demod.sv
// ofdm_qam4_demod: serial 32-sample OFDM symbol correlator and QAM4 slicer for bins {0,1,3,7}
module ofdm_qam4_demod import ofdm_pkg::*; #(
  parameter int WORD_SIZE   = 16,
  parameter int FRACTION    = 8,
  parameter int LOWCONF_THR = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic                        i_sof,
  input  logic signed [WORD_SIZE-1:0] i_re,
  input  logic signed [WORD_SIZE-1:0] i_im,
  output logic                        o_ready,
  output logic [7:0]                  o_byte,
  output logic                        o_byte_valid,
  output logic                        o_low_conf
);
  localparam int AW = WORD_SIZE + 6;
  localparam int PW = 2 * WORD_SIZE + 1;
  localparam logic signed [AW-1:0] THR = AW'(LOWCONF_THR);
  state_t state;
  logic [LOG2_N-1:0] m, cur;
  logic accept;
  logic [LOG2_N-1:0] idx [N_BINS];
  logic signed [WORD_SIZE-1:0] cos_val [N_BINS], sin_val [N_BINS];
  logic signed [PW-1:0] pr [N_BINS], pi [N_BINS];
  logic signed [AW-1:0] acc_re [N_BINS], acc_im [N_BINS];
  logic signed [AW-1:0] nxt_re [N_BINS], nxt_im [N_BINS];
  logic signed [AW-1:0] sc_re [N_BINS], sc_im [N_BINS];
  logic [7:0] byte_d;
  logic low_d;
  assign accept = i_valid & o_ready;
  assign cur = i_sof ? '0 : m;
  twiddle_rom32 #(.WORD_SIZE(WORD_SIZE)) u_rom (
    .idx(idx),
    .cos_val(cos_val),
    .sin_val(sin_val)
  );
  // sof restarts the symbol: the sample is m=0 and the old sums are dropped
  always_comb begin
    byte_d = '0;
    low_d = 1'b0;
    for (int b = 0; b < N_BINS; b++) begin
      idx[b] = LOG2_N'(BINS[b] * int'(cur));
      pr[b] = PW'(i_re) * PW'(cos_val[b]) - PW'(i_im) * PW'(sin_val[b]);
      pi[b] = PW'(i_re) * PW'(sin_val[b]) + PW'(i_im) * PW'(cos_val[b]);
      nxt_re[b] = (i_sof ? '0 : acc_re[b]) + AW'(pr[b] >>> FRACTION);
      nxt_im[b] = (i_sof ? '0 : acc_im[b]) + AW'(pi[b] >>> FRACTION);
      sc_re[b] = acc_re[b] >>> LOG2_N;
      sc_im[b] = acc_im[b] >>> LOG2_N;
      byte_d[2*b +: 2] = qam4_slice(sc_re[b][AW-1], sc_im[b][AW-1]);
      if ((sc_re[b] > -THR && sc_re[b] < THR) || (sc_im[b] > -THR && sc_im[b] < THR))
        low_d = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ACCUM;
      m <= '0;
      o_ready <= 1'b1;
      o_byte <= '0;
      o_byte_valid <= 1'b0;
      o_low_conf <= 1'b0;
      for (int b = 0; b < N_BINS; b++) begin
        acc_re[b] <= '0;
        acc_im[b] <= '0;
      end
    end else begin
      o_byte_valid <= 1'b0;
      if (accept) begin
        m <= cur + 1'b1;
        for (int b = 0; b < N_BINS; b++) begin
          acc_re[b] <= nxt_re[b];
          acc_im[b] <= nxt_im[b];
        end
      end
      if (state == DECIDE) begin
        state <= OUT;
        o_ready <= 1'b1;
        o_byte_valid <= 1'b1;
        o_byte <= byte_d;
        o_low_conf <= low_d;
        for (int b = 0; b < N_BINS; b++) begin
          acc_re[b] <= '0;
          acc_im[b] <= '0;
        end
      end else if (accept && cur == LOG2_N'(N_FFT - 1)) begin
        state <= DECIDE;
        o_ready <= 1'b0;
      end else begin
        state <= ACCUM;
      end
    end
  end
endmodule
